// File: rtl/task_3_output.sv
// Output stage: buffers one packet from the core, then replays it over
// AXI-Stream. The whole packet is collected before it is sent, so a write and
// a read never happen in the same cycle.
module task_3_output #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_enb,
  input  logic       i_last,
  input  logic       i_tready,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  output logic       o_tlast,
  output logic       o_output_last,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_overflow
);

  typedef enum logic [1:0] {s_IDLE, s_COLLECT, s_SEND, s_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  logic accepting;
  logic wr_en;
  logic rd_en;
  logic drop;

  assign accepting = (state_q == s_IDLE) || (state_q == s_COLLECT);
  assign wr_en     = i_enb && accepting && !o_full;
  // Any strobe that cannot be stored is lost and flagged.
  assign drop      = i_enb && !wr_en;
  assign rd_en     = o_tvalid && i_tready;

  // Stream and status outputs decoded from state and occupancy.
  always_comb begin
    o_full        = (count_q == (AW + 1)'(DEPTH));
    o_tvalid      = (state_q == s_SEND) && (count_q != '0);
    o_tlast       = o_tvalid && (count_q == (AW + 1)'(1));
    o_tdata       = mem[rd_ptr_q];
    o_output_last = (state_q == s_DONE);
    o_busy        = (state_q != s_IDLE);
    o_overflow    = overflow_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_IDLE: begin
        if (i_enb && i_last)  state_d = s_SEND;
        else if (i_enb)       state_d = s_COLLECT;
      end
      s_COLLECT: begin
        if (i_enb && i_last)  state_d = s_SEND;
      end
      s_SEND: begin
        // Empty packet (every byte dropped) finishes immediately.
        if (count_q == '0)         state_d = s_DONE;
        else if (rd_en && o_tlast) state_d = s_DONE;
      end
      s_DONE: begin
        state_d = s_IDLE;
      end
      default: state_d = s_IDLE;
    endcase
  end

  // State, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= s_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        count_q  <= count_q + (AW + 1)'(1);
      end else if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q  <= count_q - (AW + 1)'(1);
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Packet storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_data;
  end

endmodule

// File: tb/tb_task_3_output.sv
// Directed bench for task_3_output: nominal packet, back-pressure, single
// byte, buffer overflow, strobes during send, and reset mid-packet.
module tb_task_3_output;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_enb;
  logic       i_last;
  logic       i_tready;
  logic [7:0] o_tdata;
  logic       o_tvalid;
  logic       o_tlast;
  logic       o_output_last;
  logic       o_busy;
  logic       o_full;
  logic       o_overflow;

  int tests = 0;
  int fails = 0;

  task_3_output #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_enb         (i_enb),
    .i_last        (i_last),
    .i_tready      (i_tready),
    .o_tdata       (o_tdata),
    .o_tvalid      (o_tvalid),
    .o_tlast       (o_tlast),
    .o_output_last (o_output_last),
    .o_busy        (o_busy),
    .o_full        (o_full),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Flags packed as {tvalid, tlast, output_last, busy, full, overflow}.
  logic [5:0] flags;
  assign flags = {o_tvalid, o_tlast, o_output_last, o_busy, o_full, o_overflow};

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    i_enb  = 1'b1;
    i_data = d;
    i_last = l;
    tick();
    i_enb  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  logic [7:0] pkt [4];
  int idx;
  int cyc;

  initial begin
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    i_rst = 1'b1; i_data = '0; i_enb = 1'b0; i_last = 1'b0; i_tready = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    chk("reset_flags", 32'(flags), 32'h0);

    // Nominal 4-byte packet, downstream always ready.
    wr(8'h11, 1'b0);
    chk("collect_busy", 32'(flags), 32'b000100);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    wr(8'h44, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_valid%0d", i), 32'(o_tvalid), 32'h1);
      chk($sformatf("t1_data%0d", i), 32'(o_tdata), 32'(pkt[i]));
      chk($sformatf("t1_last%0d", i), 32'(o_tlast), 32'(i == 3));
      chk($sformatf("t1_ol%0d", i), 32'(o_output_last), 32'h0);
      tick();
    end
    chk("t1_done_flags", 32'(flags), 32'b001100);
    tick();
    chk("t1_idle_flags", 32'(flags), 32'h0);

    // Same packet with tready pattern 1,0,0,1,0,0,...
    for (int i = 0; i < 4; i++) wr(pkt[i], i == 3);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      i_tready = (cyc % 3 == 0);
      chk($sformatf("t2_valid_c%0d", cyc), 32'(o_tvalid), 32'h1);
      chk($sformatf("t2_data_c%0d", cyc), 32'(o_tdata), 32'(pkt[idx]));
      chk($sformatf("t2_last_c%0d", cyc), 32'(o_tlast), 32'(idx == 3));
      if (i_tready) idx++;
      tick();
      cyc++;
    end
    i_tready = 1'b1;
    chk("t2_beats", 32'(idx), 32'd4);
    chk("t2_done_flags", 32'(flags), 32'b001100);
    tick();
    chk("t2_idle_flags", 32'(flags), 32'h0);

    // Single-byte packet.
    wr(8'hA5, 1'b1);
    chk("t3_flags", 32'(flags), 32'b110100);
    chk("t3_data", 32'(o_tdata), 32'hA5);
    tick();
    chk("t3_done_flags", 32'(flags), 32'b001100);
    tick();
    chk("t3_idle_flags", 32'(flags), 32'h0);

    // DEPTH+2 bytes: last two are dropped, packet still closes.
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 1'b0);
    chk("t4_full", 32'(flags), 32'b000110);
    wr(8'hEE, 1'b0);
    chk("t4_ovf", 32'(flags), 32'b000111);
    wr(8'hEF, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if (!o_tvalid || o_tdata !== 8'(i) || o_tlast !== (i == DEPTH - 1)) begin
        chk($sformatf("t4_beat%0d", i), {23'h0, o_tvalid, o_tlast, o_tdata},
            {23'h0, 1'b1, 1'(i == DEPTH - 1), 8'(i)});
      end
      tick();
    end
    chk("t4_done_flags", 32'(flags), 32'b001101);
    tick();
    chk("t4_idle_flags", 32'(flags), 32'b000001);
    do_reset();
    chk("t4_reset_clears", 32'(flags), 32'h0);

    // Strobes during send are dropped and flagged; stream unaffected.
    for (int i = 0; i < 4; i++) wr(pkt[i], i == 3);
    for (int i = 0; i < 4; i++) begin
      i_enb  = 1'b1;
      i_data = 8'hFF;
      i_last = (i == 1);
      chk($sformatf("t5_data%0d", i), 32'(o_tdata), 32'(pkt[i]));
      chk($sformatf("t5_last%0d", i), 32'(o_tlast), 32'(i == 3));
      chk($sformatf("t5_valid%0d", i), 32'(o_tvalid), 32'h1);
      tick();
    end
    i_enb  = 1'b0;
    i_last = 1'b0;
    chk("t5_done_flags", 32'(flags), 32'b001101);
    tick();
    chk("t5_idle_flags", 32'(flags), 32'b000001);

    // Reset after two of four bytes sent.
    for (int i = 0; i < 4; i++) wr(pkt[i], i == 3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t6_data%0d", i), 32'(o_tdata), 32'(pkt[i]));
      tick();
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_quiet%0d", i), 32'(flags), 32'h0);
      tick();
    end
    wr(8'h5A, 1'b0);
    wr(8'hC3, 1'b1);
    chk("t6_b0", {22'h0, o_tvalid, o_tlast, o_tdata}, {22'h0, 2'b10, 8'h5A});
    tick();
    chk("t6_b1", {22'h0, o_tvalid, o_tlast, o_tdata}, {22'h0, 2'b11, 8'hC3});
    tick();
    chk("t6_done_flags", 32'(flags), 32'b001100);
    tick();
    chk("t6_idle_flags", 32'(flags), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
